// File: rtl/instr_issue_sequencer_pkg.sv
// instr_issue_sequencer_pkg: phase and error encodings shared by the issue sequencer
package instr_issue_sequencer_pkg;
    typedef enum logic [1:0] {PH_DEC = 2'd0, PH_SETUP = 2'd1, PH_EXEC = 2'd2, PH_WB = 2'd3} phase_e;
    typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_ONEHOT = 2'd1, ERR_TRANS = 2'd2, ERR_ACTIVE = 2'd3} err_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} chk_state_e;
    function automatic phase_e encode_phase(input logic [3:0] s);
        return s[3] ? PH_WB : s[2] ? PH_EXEC : s[1] ? PH_SETUP : PH_DEC;
    endfunction
endpackage

// File: rtl/instr_issue_sequencer_issue_fifo.sv
// instr_issue_sequencer_issue_fifo: registered issue FIFO with wrapping pointers and occupancy count
module instr_issue_sequencer_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_rdata = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/instr_issue_sequencer.sv
// instr_issue_sequencer: buffers fetched words, starts the pipeline controller and checks its phase protocol
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               active,
    input  logic               decode_state,
    input  logic               setup_state,
    input  logic               execute_state,
    input  logic               writeback_state,
    output logic               start,
    output logic [INSTR_W-1:0] cur_instr,
    output logic               cur_valid,
    output logic [1:0]         phase,
    output logic               retire_pulse,
    output logic [CNT_W-1:0]   retire_count,
    output logic               proto_error,
    output logic [1:0]         error_code
);
    logic               w_full, w_empty, w_onehot, w_wb_done, w_run;
    logic [INSTR_W-1:0] w_head;
    logic [3:0]         w_strobes;
    phase_e             w_phase, r_prev_phase;
    err_e               w_err;
    chk_state_e         r_state, w_state_nx;
    logic               r_prev_start;

    instr_issue_sequencer_issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_issue_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (in_valid),
        .i_pop   (start),
        .i_wdata (in_instr),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_strobes = {writeback_state, execute_state, setup_state, decode_state};
    assign w_onehot  = (w_strobes != 4'd0) && ((w_strobes & (w_strobes - 4'd1)) == 4'd0);
    assign w_phase   = w_onehot ? encode_phase(w_strobes) : PH_DEC;
    assign phase     = w_phase;
    assign in_ready  = !w_full;
    assign start     = decode_state && !active && !w_empty && !proto_error;
    assign w_wb_done = active && writeback_state;
    assign w_run     = r_state == ST_RUN;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    // Wrap wb->dec is arithmetically prev+1, so the "stays active into decode" case must win over code 2
    always_comb begin
        w_state_nx = active ? ST_RUN : ST_IDLE;
        w_err = !w_onehot ? ERR_ONEHOT :
                (w_run && !active && r_prev_phase != PH_WB) ||
                (w_run && active && r_prev_phase == PH_WB && w_phase == PH_DEC) ? ERR_ACTIVE :
                (w_run && active && w_phase != phase_e'(r_prev_phase + 2'd1)) ||
                (!w_run && active && !r_prev_start) ? ERR_TRANS : ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev_phase <= PH_DEC;
            r_prev_start <= 1'b0;
            cur_instr    <= '0;
            cur_valid    <= 1'b0;
            retire_pulse <= 1'b0;
            retire_count <= '0;
            proto_error  <= 1'b0;
            error_code   <= ERR_NONE;
        end else begin
            r_prev_phase <= w_phase;
            r_prev_start <= start;
            retire_pulse <= w_wb_done;
            if (w_wb_done) retire_count <= retire_count + 1'b1;
            if (start) begin
                cur_instr <= w_head;
                cur_valid <= 1'b1;
            end else if (w_wb_done) begin
                cur_valid <= 1'b0;
            end
            if (!proto_error && w_err != ERR_NONE) begin
                proto_error <= 1'b1;
                error_code  <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_instr_issue_sequencer.sv
// tb_instr_issue_sequencer: scoreboard bench with a behavioural pipeline controller and FIFO model
module tb_instr_issue_sequencer;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, start, cur_valid, retire_pulse, proto_error;
    logic        active, decode_state, setup_state, execute_state, writeback_state;
    logic [31:0] in_instr, cur_instr;
    logic [1:0]  phase, error_code;
    logic [15:0] retire_count;
    logic        ctl_en, chk_en, b2b, seen_full_pop, seen_full;
    logic [4:0]  d_str;
    int          ctl_step, cyc, last_start;
    int          errors = 0, checks = 0;
    logic [31:0] q[$];
    logic [31:0] m_cur, n_data;
    logic        m_cv, n_push, n_start, n_wb;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    assign active          = ctl_en ? (ctl_step != 0) : d_str[4];
    assign writeback_state = ctl_en ? (ctl_step == 4) : d_str[3];
    assign execute_state   = ctl_en ? (ctl_step == 3) : d_str[2];
    assign setup_state     = ctl_en ? (ctl_step == 2) : d_str[1];
    assign decode_state    = ctl_en ? (ctl_step <= 1) : d_str[0];

    instr_issue_sequencer dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .active(active), .decode_state(decode_state), .setup_state(setup_state),
        .execute_state(execute_state), .writeback_state(writeback_state), .start(start),
        .cur_instr(cur_instr), .cur_valid(cur_valid), .phase(phase), .retire_pulse(retire_pulse),
        .retire_count(retire_count), .proto_error(proto_error), .error_code(error_code)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller: idle until start, then dec, setup, exec, wb, back to idle
    initial begin
        logic s, r, e;
        ctl_step = 0;
        forever begin
            @(negedge clk);
            s = start; r = reset_n; e = ctl_en;
            @(posedge clk);
            #1;
            if (!r || !e) ctl_step = 0;
            else if (ctl_step == 0) ctl_step = s ? 1 : 0;
            else ctl_step = (ctl_step == 4) ? 0 : ctl_step + 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("start", 64'(start), 64'(ctl_step == 0 && q.size() > 0));
            n_push  = in_valid && q.size() < DEPTH;
            n_start = ctl_step == 0 && q.size() > 0;
            n_wb    = ctl_step == 4;
            n_data  = in_instr;
            if (b2b && !in_ready) seen_full = 1'b1;
            if (b2b && start) begin
                if (last_start >= 0) chk("start_period", 64'(cyc - last_start), 64'd5);
                last_start = cyc;
                if (!in_ready && in_valid) seen_full_pop = 1'b1;
            end
        end else begin
            n_push = 1'b0; n_start = 1'b0; n_wb = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!chk_en) begin
            q.delete(); m_cnt = '0; m_cv = 1'b0; m_cur = '0;
        end else begin
            logic st, wb;
            st = n_start; wb = n_wb;
            if (st) begin
                m_cur = q.pop_front();
                m_cv  = 1'b1;
            end else if (wb) begin
                m_cv = 1'b0;
            end
            if (n_push) q.push_back(n_data);
            if (wb) m_cnt++;
            #1;
            chk("cur_valid", 64'(cur_valid), 64'(m_cv));
            if (m_cv) chk("cur_instr", 64'(cur_instr), 64'(m_cur));
            chk("retire_pulse", 64'(retire_pulse), 64'(wb));
            chk("retire_count", 64'(retire_count), 64'(m_cnt));
        end
    end

    task automatic push(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_instr = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(q.size() == 0 && ctl_step == 0 && !cur_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(n < 300), 64'd1);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; in_valid = 1'b1; in_instr = 32'h1234_5678;
        ctl_en = 1'b0; chk_en = 1'b0; d_str = 5'b00001;
        b2b = 1'b0; seen_full_pop = 1'b0; seen_full = 1'b0; last_start = -1; cyc = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_cur_valid", 64'(cur_valid), 64'd0);
        chk("rst_retire_count", 64'(retire_count), 64'd0);
        chk("rst_proto_error", 64'(proto_error), 64'd0);
        tick();
        reset_n = 1'b1; in_valid = 1'b0; ctl_en = 1'b1; chk_en = 1'b1;

        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_start", 64'(start), 64'd1);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (retire_pulse) break;
        end
        chk("single_latency", 64'(n), 64'd5);
        chk("single_count", 64'(retire_count), 64'd1);
        chk("single_instr", 64'(cur_instr), 64'hDEAD_BEEF);

        b2b = 1'b1; last_start = -1;
        for (int i = 0; i < 6; i++) push(32'hB000_0000 + 32'(i));
        drain();
        b2b = 1'b0;
        chk("b2b_full_seen", 64'(seen_full), 64'd1);
        chk("full_pop_push_seen", 64'(seen_full_pop), 64'd1);
        chk("b2b_count", 64'(retire_count), 64'd7);

        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) == 0;
            in_instr = $urandom;
            tick();
        end
        in_valid = 1'b0;
        drain();

        chk_en = 1'b0; ctl_en = 1'b0; d_str = 5'b00001;
        in_valid = 1'b1; in_instr = 32'hCAFE_0001;
        tick();
        in_instr = 32'hF00D_0002;
        @(negedge clk);
        chk("skip_start", 64'(start), 64'd1);
        tick();
        in_valid = 1'b0; d_str = 5'b10001;
        @(negedge clk);
        chk("skip_legal_rise", 64'(proto_error), 64'd0);
        chk("skip_cur_instr", 64'(cur_instr), 64'hCAFE_0001);
        tick();
        d_str = 5'b10100;
        @(negedge clk);
        chk("skip_phase", 64'(phase), 64'd2);
        tick();
        chk("skip_proto_error", 64'(proto_error), 64'd1);
        chk("skip_error_code", 64'(error_code), 64'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; d_str = 5'b00001;
        @(negedge clk);
        chk("mid_rst_cur_valid", 64'(cur_valid), 64'd0);
        chk("mid_rst_cur_instr", 64'(cur_instr), 64'd0);
        chk("mid_rst_count", 64'(retire_count), 64'd0);
        chk("mid_rst_proto_error", 64'(proto_error), 64'd0);
        chk("mid_rst_error_code", 64'(error_code), 64'd0);
        chk("mid_rst_fifo_empty", 64'(start), 64'd0);
        chk("mid_rst_pulse", 64'(retire_pulse), 64'd0);

        tick();
        d_str = 5'b00110;
        @(negedge clk);
        chk("onehot_phase", 64'(phase), 64'd0);
        tick();
        d_str = 5'b00001;
        @(negedge clk);
        chk("onehot_proto_error", 64'(proto_error), 64'd1);
        chk("onehot_error_code", 64'(error_code), 64'd1);
        in_valid = 1'b1; in_instr = 32'h0BAD_0BAD;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_start_gated", 64'(start), 64'd0);
            tick();
        end
        chk("err_cur_valid", 64'(cur_valid), 64'd0);
        chk("err_code_held", 64'(error_code), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
